// File: rtl/turing_machine_mc.sv
// Programmable multi-symbol Turing machine with a loadable rule table and tape, supporting
// free-run and single-step modes with halt, fault and timeout reporting and tape readback.
module turing_machine_mc #(
   parameter int unsigned SYM_W    = 2,
   parameter int unsigned STATE_W  = 3,
   parameter int unsigned TAPE_LEN = 64,
   parameter int unsigned HEAD_W   = $clog2(TAPE_LEN),
   parameter int unsigned CNT_W    = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       prog_we,
   input  logic [STATE_W+SYM_W-1:0]   prog_addr,
   input  logic [STATE_W+SYM_W+1:0]   prog_data,
   input  logic                       tape_we,
   input  logic [HEAD_W-1:0]          tape_addr,
   input  logic [SYM_W-1:0]           tape_wdata,
   output logic [SYM_W-1:0]           tape_rdata,
   input  logic [HEAD_W-1:0]          head_init,
   input  logic                       start,
   input  logic                       step_mode,
   input  logic                       step,
   input  logic                       abort,
   output logic                       busy,
   output logic                       halted,
   output logic                       fault,
   output logic                       timeout,
   output logic [HEAD_W-1:0]          head,
   output logic [STATE_W-1:0]         cur_state,
   output logic [CNT_W-1:0]           step_count
);

   localparam int unsigned ADDR_W     = STATE_W + SYM_W;
   localparam int unsigned RULE_W     = STATE_W + SYM_W + 2;
   localparam int unsigned RULES      = 2 ** ADDR_W;
   localparam int unsigned TAPE_LAST  = TAPE_LEN - 1;
   localparam int unsigned TAPE_LEN_U = TAPE_LEN;

   localparam logic [HEAD_W:0]   TAPE_LEN_EXT = TAPE_LEN_U[HEAD_W:0];
   localparam logic [HEAD_W-1:0] HEAD_MAX     = TAPE_LAST[HEAD_W-1:0];
   localparam logic [HEAD_W-1:0] HEAD_ONE     = HEAD_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);

   localparam logic [1:0] MOVE_RIGHT = 2'b01;
   localparam logic [1:0] MOVE_LEFT  = 2'b10;
   localparam logic [1:0] MOVE_HALT  = 2'b11;

   typedef enum logic [2:0] {StIdle, StRdTape, StRdRule, StExec, StPause, StDone} state_e;

   state_e              state_q, state_d;
   logic [HEAD_W-1:0]   head_q, head_d;
   logic [STATE_W-1:0]  mstate_q, mstate_d;
   logic [CNT_W-1:0]    count_q, count_d, count_inc;
   logic                halted_q, halted_d;
   logic                fault_q, fault_d;
   logic                timeout_q, timeout_d;

   logic [SYM_W-1:0]    tape_mem [TAPE_LEN];
   logic [RULE_W-1:0]   rule_mem [RULES];
   logic [SYM_W-1:0]    sym_q;
   logic [RULE_W-1:0]   rule_q;

   logic [STATE_W-1:0]  rule_next;
   logic [SYM_W-1:0]    rule_wsym;
   logic [1:0]          rule_move;
   logic                exec_we;
   logic                tape_addr_ok;
   logic                head_init_bad;

   assign rule_next     = rule_q[RULE_W-1 -: STATE_W];
   assign rule_wsym     = rule_q[2 +: SYM_W];
   assign rule_move     = rule_q[1:0];
   assign busy          = (state_q != StIdle) && (state_q != StDone);
   // An abort arriving in EXEC cancels that step, including its tape write.
   assign exec_we       = (state_q == StExec) && !abort;
   assign tape_addr_ok  = {1'b0, tape_addr} < TAPE_LEN_EXT;
   assign head_init_bad = {1'b0, head_init} >= TAPE_LEN_EXT;

   always_ff @(posedge clock) begin
      if (exec_we) begin
         tape_mem[head_q] <= rule_wsym;
      end else if (tape_we && !busy && tape_addr_ok) begin
         tape_mem[tape_addr] <= tape_wdata;
      end
      if (state_q == StRdTape) begin
         sym_q <= tape_mem[head_q];
      end
   end

   always_ff @(posedge clock) begin
      if (prog_we && !busy) begin
         rule_mem[prog_addr] <= prog_data;
      end
      if (state_q == StRdRule) begin
         rule_q <= rule_mem[{mstate_q, sym_q}];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tape_rdata <= '0;
      end else begin
         tape_rdata <= tape_addr_ok ? tape_mem[tape_addr] : '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         head_q    <= '0;
         mstate_q  <= '0;
         count_q   <= '0;
         halted_q  <= 1'b0;
         fault_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         head_q    <= head_d;
         mstate_q  <= mstate_d;
         count_q   <= count_d;
         halted_q  <= halted_d;
         fault_q   <= fault_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      head_d    = head_q;
      mstate_d  = mstate_q;
      count_d   = count_q;
      halted_d  = halted_q;
      fault_d   = fault_q;
      timeout_d = timeout_q;
      count_inc = count_q + CNT_ONE;

      if (abort) begin
         state_d   = StIdle;
         halted_d  = 1'b0;
         fault_d   = 1'b0;
         timeout_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  head_d    = head_init;
                  mstate_d  = '0;
                  count_d   = '0;
                  halted_d  = 1'b0;
                  timeout_d = 1'b0;
                  fault_d   = head_init_bad;
                  state_d   = head_init_bad ? StDone : StRdTape;
               end
            end
            StRdTape: state_d = StRdRule;
            StRdRule: state_d = StExec;
            StExec: begin
               count_d   = count_inc;
               // Saturation is flagged alongside halt or fault on the same step.
               timeout_d = &count_inc;
               if (rule_move == MOVE_HALT) begin
                  halted_d = 1'b1;
                  state_d  = StDone;
               end else if ((rule_move == MOVE_LEFT && head_q == '0) ||
                            (rule_move == MOVE_RIGHT && head_q == HEAD_MAX)) begin
                  fault_d = 1'b1;
                  state_d = StDone;
               end else begin
                  mstate_d = rule_next;
                  if (rule_move == MOVE_RIGHT) begin
                     head_d = head_q + HEAD_ONE;
                  end else if (rule_move == MOVE_LEFT) begin
                     head_d = head_q - HEAD_ONE;
                  end
                  if (&count_inc) begin
                     state_d = StDone;
                  end else if (step_mode) begin
                     state_d = StPause;
                  end else begin
                     state_d = StRdTape;
                  end
               end
            end
            StPause: begin
               if (step || !step_mode) begin
                  state_d = StRdTape;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign halted     = halted_q;
   assign fault      = fault_q;
   assign timeout    = timeout_q;
   assign head       = head_q;
   assign cur_state  = mstate_q;
   assign step_count = count_q;

endmodule

// File: tb/tb_turing_machine_mc.sv
// Directed bench for turing_machine_mc: a default instance plus a 4-bit-counter instance
// sharing all inputs, so the timeout case runs in a few dozen cycles.
module tb_turing_machine_mc;

   localparam int unsigned SYM_W   = 2;
   localparam int unsigned STATE_W = 3;
   localparam int unsigned HEAD_W  = 6;

   logic                     clock;
   logic                     reset;
   logic                     prog_we;
   logic [STATE_W+SYM_W-1:0] prog_addr;
   logic [STATE_W+SYM_W+1:0] prog_data;
   logic                     tape_we;
   logic [HEAD_W-1:0]        tape_addr;
   logic [SYM_W-1:0]         tape_wdata;
   logic [HEAD_W-1:0]        head_init;
   logic                     start, step_mode, step, abort;

   logic [SYM_W-1:0]   tape_rdata, tape_rdata_s;
   logic               busy, halted, fault, timeout;
   logic               busy_s, halted_s, fault_s, timeout_s;
   logic [HEAD_W-1:0]  head, head_s;
   logic [STATE_W-1:0] cur_state, cur_state_s;
   logic [15:0]        step_count;
   logic [3:0]         step_count_s;

   turing_machine_mc dut (
      .clock(clock), .reset(reset),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .tape_we(tape_we), .tape_addr(tape_addr), .tape_wdata(tape_wdata),
      .tape_rdata(tape_rdata), .head_init(head_init),
      .start(start), .step_mode(step_mode), .step(step), .abort(abort),
      .busy(busy), .halted(halted), .fault(fault), .timeout(timeout),
      .head(head), .cur_state(cur_state), .step_count(step_count)
   );

   turing_machine_mc #(.CNT_W(4)) dut_small (
      .clock(clock), .reset(reset),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .tape_we(tape_we), .tape_addr(tape_addr), .tape_wdata(tape_wdata),
      .tape_rdata(tape_rdata_s), .head_init(head_init),
      .start(start), .step_mode(step_mode), .step(step), .abort(abort),
      .busy(busy_s), .halted(halted_s), .fault(fault_s), .timeout(timeout_s),
      .head(head_s), .cur_state(cur_state_s), .step_count(step_count_s)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic set_rule(input logic [2:0] st, input logic [1:0] sym, input logic [2:0] ns,
                           input logic [1:0] ws, input logic [1:0] mv);
      prog_we   = 1'b1;
      prog_addr = {st, sym};
      prog_data = {ns, ws, mv};
      tick();
      prog_we   = 1'b0;
   endtask

   task automatic set_cell(input logic [5:0] a, input logic [1:0] d);
      tape_we    = 1'b1;
      tape_addr  = a;
      tape_wdata = d;
      tick();
      tape_we    = 1'b0;
   endtask

   task automatic check_cell(input string tag, input logic [5:0] a, input logic [1:0] exp);
      tape_addr = a;
      tick();
      check_eq(tag, 32'(tape_rdata), 32'(exp));
   endtask

   task automatic pulse_start(input logic [5:0] h);
      head_init = h;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int max_cycles);
      int n = 0;
      while (busy && n < max_cycles) begin
         tick();
         n++;
      end
      check_eq(tag, 32'(busy), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      tape_we = 1'b0; tape_addr = '0; tape_wdata = '0;
      head_init = '0; start = 1'b0; step_mode = 1'b0; step = 1'b0; abort = 1'b0;
      ticks(3);

      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_halted", 32'(halted), 32'd0);
      check_eq("rst_fault", 32'(fault), 32'd0);
      check_eq("rst_timeout", 32'(timeout), 32'd0);
      check_eq("rst_head", 32'(head), 32'd0);
      check_eq("rst_state", 32'(cur_state), 32'd0);
      check_eq("rst_count", 32'(step_count), 32'd0);
      check_eq("rst_rdata", 32'(tape_rdata), 32'd0);
      reset = 1'b0;
      tick();

      // Binary increment 7 -> 8; symbol 1 = bit 0, symbol 2 = bit 1, carry runs leftwards.
      set_rule(3'd0, 2'd2, 3'd0, 2'd1, 2'b10);
      set_rule(3'd0, 2'd1, 3'd1, 2'd2, 2'b00);
      set_rule(3'd0, 2'd0, 3'd1, 2'd2, 2'b00);
      set_rule(3'd1, 2'd2, 3'd1, 2'd2, 2'b11);
      set_cell(6'd5, 2'd2);
      set_cell(6'd4, 2'd2);
      set_cell(6'd3, 2'd2);
      set_cell(6'd2, 2'd0);
      pulse_start(6'd5);
      wait_idle("inc_done", 40);
      check_eq("inc_halted", 32'(halted), 32'd1);
      check_eq("inc_fault", 32'(fault), 32'd0);
      check_eq("inc_count", 32'(step_count), 32'd5);
      check_eq("inc_head", 32'(head), 32'd2);
      check_eq("inc_state", 32'(cur_state), 32'd1);
      check_cell("inc_cell5", 6'd5, 2'd1);
      check_cell("inc_cell4", 6'd4, 2'd1);
      check_cell("inc_cell3", 6'd3, 2'd1);
      check_cell("inc_cell2", 6'd2, 2'd2);

      // Left edge: moving left from cell 0 faults but the write still lands.
      set_rule(3'd0, 2'd0, 3'd0, 2'd1, 2'b10);
      set_cell(6'd0, 2'd0);
      pulse_start(6'd0);
      ticks(5);
      check_eq("ledge_busy", 32'(busy), 32'd0);
      check_eq("ledge_fault", 32'(fault), 32'd1);
      check_eq("ledge_halted", 32'(halted), 32'd0);
      check_eq("ledge_head", 32'(head), 32'd0);
      check_eq("ledge_count", 32'(step_count), 32'd1);
      check_cell("ledge_cell0", 6'd0, 2'd1);

      // Right edge: always-right from 60 faults on the fourth step at 63.
      set_rule(3'd0, 2'd0, 3'd0, 2'd0, 2'b01);
      for (int i = 60; i < 64; i++) set_cell(i[5:0], 2'd0);
      pulse_start(6'd60);
      wait_idle("redge_done", 40);
      check_eq("redge_fault", 32'(fault), 32'd1);
      check_eq("redge_head", 32'(head), 32'd63);
      check_eq("redge_count", 32'(step_count), 32'd4);

      // Single-step mode with a two-step program.
      set_rule(3'd0, 2'd0, 3'd1, 2'd3, 2'b01);
      set_rule(3'd1, 2'd0, 3'd0, 2'd2, 2'b11);
      set_cell(6'd10, 2'd0);
      set_cell(6'd11, 2'd0);
      step_mode = 1'b1;
      pulse_start(6'd10);
      ticks(10);
      check_eq("step_busy", 32'(busy), 32'd1);
      check_eq("step_count1", 32'(step_count), 32'd1);
      check_eq("step_halted0", 32'(halted), 32'd0);
      check_eq("step_head", 32'(head), 32'd11);
      check_eq("step_state", 32'(cur_state), 32'd1);
      step = 1'b1;
      tick();
      step = 1'b0;
      wait_idle("step_done", 10);
      check_eq("step_count2", 32'(step_count), 32'd2);
      check_eq("step_halted1", 32'(halted), 32'd1);
      step_mode = 1'b0;
      check_cell("step_cell10", 6'd10, 2'd3);
      check_cell("step_cell11", 6'd11, 2'd2);

      // Stay-forever: small instance times out, default instance is aborted mid-run.
      set_rule(3'd0, 2'd0, 3'd0, 2'd0, 2'b00);
      set_cell(6'd30, 2'd0);
      set_cell(6'd20, 2'd1);
      pulse_start(6'd30);
      ticks(10);
      // Rule rewrite, tape write and restart are all issued while busy and must be ignored.
      prog_we    = 1'b1;
      prog_addr  = {3'd0, 2'd0};
      prog_data  = {3'd0, 2'd0, 2'b11};
      tape_we    = 1'b1;
      tape_addr  = 6'd20;
      tape_wdata = 2'd3;
      start      = 1'b1;
      head_init  = 6'd40;
      tick();
      prog_we = 1'b0; tape_we = 1'b0; start = 1'b0;
      ticks(39);
      check_eq("tmo_timeout", 32'(timeout_s), 32'd1);
      check_eq("tmo_count", 32'(step_count_s), 32'd15);
      check_eq("tmo_halted", 32'(halted_s), 32'd0);
      check_eq("tmo_busy", 32'(busy_s), 32'd0);
      check_eq("lock_busy", 32'(busy), 32'd1);
      check_eq("lock_count", 32'(step_count), 32'd16);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_flags", 32'({halted, fault, timeout}), 32'd0);
      check_eq("abort_count", 32'(step_count), 32'd16);
      check_eq("abort_head", 32'(head), 32'd30);
      check_eq("abort_small_tmo", 32'(timeout_s), 32'd0);
      ticks(3);
      check_eq("abort_hold", 32'(step_count), 32'd16);
      check_cell("lock_cell20", 6'd20, 2'd1);
      check_cell("abort_cell30", 6'd30, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/turing_machine_mc.md
Name: turing_machine_mc

Overview:
- Parametrised successor of the single-bit Turing machine. Supports a multi-symbol alphabet, a parametrised state count and tape length, and a programmable rule table.
- Adds single-step/free-run modes, explicit fault and timeout reporting, and a tape readback port.
- Sits between the board I/O sequencer (which loads rules and tape, then starts a run) and the display logic (which consumes head, cur_state, step_count and tape readback).

Parameters:
SYM_W, 2, bits per tape symbol (alphabet size 2**SYM_W)
STATE_W, 3, bits of machine state; state 0 is the initial state
TAPE_LEN, 64, number of tape cells
HEAD_W, $clog2(TAPE_LEN), head/tape address width
CNT_W, 16, step counter width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
prog_we  in  1  write one rule-table entry
prog_addr  in  STATE_W+SYM_W  {state, read_symbol}
prog_data  in  STATE_W+SYM_W+2  {next_state, write_symbol, move}
tape_we  in  1  write one tape cell
tape_addr  in  HEAD_W  tape write / readback address
tape_wdata  in  SYM_W  tape write data
tape_rdata  out  SYM_W  readback of cell tape_addr, registered
head_init  in  HEAD_W  head position sampled on start
start  in  1  begin a run (pulse)
step_mode  in  1  1 = pause after each step
step  in  1  advance one step while paused (pulse)
abort  in  1  stop run, return to IDLE
busy  out  1  run in progress (any state but IDLE/DONE)
halted  out  1  run ended on a halt rule
fault  out  1  run ended on a head-out-of-range move
timeout  out  1  run ended on step_count saturation
head  out  HEAD_W  current head position
cur_state  out  STATE_W  current machine state
step_count  out  CNT_W  completed steps in the current run

Behaviour:
- Move encoding: 00 stay, 01 right (+1), 10 left (-1), 11 halt. A halt rule still writes write_symbol; next_state is ignored.
- Rule table (2**(STATE_W+SYM_W) entries) and tape (TAPE_LEN cells) are synchronous-write, synchronous-read memories. Neither is cleared by reset.
- prog_we and tape_we are honoured only when busy=0; ignored otherwise.
- tape_rdata = tape[tape_addr] one cycle later; valid only when busy=0.
- Reset values: FSM=IDLE, busy=halted=fault=timeout=0, head=0, cur_state=0, step_count=0, tape_rdata=0.
- FSM states: IDLE, RD_TAPE, RD_RULE, EXEC, PAUSE, DONE.
- IDLE: start -> latch head<=head_init, cur_state<=0, step_count<=0, clear all status flags, go to RD_TAPE. If head_init >= TAPE_LEN: fault<=1, go to DONE.
- RD_TAPE: issue tape read at head -> RD_RULE.
- RD_RULE: issue rule read at {cur_state, symbol} -> EXEC.
- EXEC (one step every 3 cycles in free-run): write write_symbol at head; step_count+1.
  - Halt rule -> halted=1, DONE.
  - Left at head=0, or right at head=TAPE_LEN-1 -> tape written, head unchanged, fault=1, DONE.
  - Otherwise update head and cur_state.
  - If step_count reaches all-ones -> timeout=1, DONE. Otherwise go to PAUSE if step_mode=1, else RD_TAPE.
- PAUSE: step -> RD_TAPE. step_mode deasserted -> RD_TAPE.
- DONE: outputs hold. start -> restarts exactly as from IDLE.
- abort has priority over everything but reset: from any state -> IDLE next cycle. Flags are cleared; head, cur_state and step_count hold; tape contents are kept. An abort landing on EXEC suppresses that step's tape write.
- Simultaneous halt and saturation: halted=1 and timeout=1 both set.
- start while busy: ignored. Reset mid-run: immediate IDLE; memory contents are undefined but not destroyed.

Test Plan:
- Binary increment: SYM_W=2 (0 blank, 1/2 = bits 0/1), tape "1 1 1" LSB at head 5 -> final tape "0 0 0 1", halted=1, step_count=5, fault=0.
- Left edge: rule (0,sym0) = {0,sym1,left}, head_init=0 -> after 6 cycles tape[0]=1, head=0, fault=1, busy=0.
- Right edge: TAPE_LEN=64, always-right rule, head_init=60 -> fault after 4 steps, head=63, step_count=4.
- Timeout: CNT_W=4, stay-forever rule -> timeout=1, step_count=15, halted=0.
- Step mode: step_mode=1, run 2-step program -> busy stays high in PAUSE with step_count=1 until step pulse, then step_count=2, halted=1.
- Abort and locking: abort mid-run -> IDLE with flags clear. tape_we/prog_we during busy have no effect (readback unchanged). start while busy is ignored.
